cart_mapper: RTL

- Parametrised cartridge bank-switch mapper that replaces the fixed 4 KB ROM address path in the console top level.
- Sits between the 6502 address bus and the cartridge ROM/dprom and translates the 13-bit CPU address into a wide ROM address.
- Implements hotspot-driven banking for the common 2600 schemes (2K, 4K, F8, F6, F4, E0, 3F) plus optional Superchip 128-byte cart RAM.
- Mode is selected at run time by the SPI loader.

---
 rtl/cart_mapper.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cart_mapper.sv
// Cartridge bank-switch mapper: translates the 13-bit 6502 address into a wide ROM
// address for 2K/4K/F8/F6/F4/E0/3F carts, with optional Superchip RAM decode.
module cart_mapper #(
    parameter int ROM_AW     = 15,
    parameter bit SC_SUPPORT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_en_i,
    input  logic [12:0]       addr_i,
    input  logic [7:0]        data_i,
    input  logic              we_i,
    input  logic [2:0]        mode_i,
    input  logic              sc_en_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic              sc_we_o,
    output logic              sc_rd_o,
    output logic [6:0]        sc_addr_o,
    output logic              hit_o
);
    localparam int BW = ROM_AW - 12;
    localparam int FW = ROM_AW - 11;

    typedef enum logic [2:0] {
        M_2K  = 3'd0,
        M_4K  = 3'd1,
        M_F8  = 3'd2,
        M_F6  = 3'd3,
        M_F4  = 3'd4,
        M_E0  = 3'd5,
        M_3F  = 3'd6,
        M_X4K = 3'd7
    } mode_t;

    mode_t          mode_q;
    logic [BW-1:0]  bank_q;
    logic [2:0]     seg0_q, seg1_q, seg2_q;
    logic [FW-1:0]  b3f_q;

    logic           hs_bank, hs_seg0, hs_seg1, hs_seg2, hs_3f;
    logic [BW-1:0]  bank_next;
    logic [FW-1:0]  b3f_next;
    logic [FW+7:0]  data_ext;
    logic           unused_data;

    // Power-on / mode-change bank: the last bank of the scheme, truncated to width
    function automatic logic [BW-1:0] last_bank(input logic [2:0] m);
        logic [ROM_AW-1:0] v;
        case (m)
            3'd2:    v = ROM_AW'(1);
            3'd3:    v = ROM_AW'(3);
            3'd4:    v = ROM_AW'(7);
            default: v = '0;
        endcase
        return v[BW-1:0];
    endfunction

    assign data_ext    = {{FW{1'b0}}, data_i};
    assign b3f_next    = data_ext[FW-1:0];
    assign unused_data = ^data_ext[FW+7:FW];

    always_comb begin
        hs_bank   = 1'b0;
        hs_seg0   = 1'b0;
        hs_seg1   = 1'b0;
        hs_seg2   = 1'b0;
        hs_3f     = 1'b0;
        bank_next = bank_q;
        case (mode_q)
            M_F8: if (addr_i == 13'h1FF8 || addr_i == 13'h1FF9) begin
                hs_bank   = 1'b1;
                bank_next = BW'(addr_i[3:0] - 4'd8);
            end
            M_F6: if (addr_i >= 13'h1FF6 && addr_i <= 13'h1FF9) begin
                hs_bank   = 1'b1;
                bank_next = BW'(addr_i[3:0] - 4'd6);
            end
            M_F4: if (addr_i >= 13'h1FF4 && addr_i <= 13'h1FFB) begin
                hs_bank   = 1'b1;
                bank_next = BW'(addr_i[3:0] - 4'd4);
            end
            M_E0: if (addr_i[12:5] == 8'hFF) begin
                hs_seg0 = (addr_i[4:3] == 2'd0);
                hs_seg1 = (addr_i[4:3] == 2'd1);
                hs_seg2 = (addr_i[4:3] == 2'd2);
            end
            M_3F: hs_3f = we_i && !addr_i[12] && (addr_i[7:6] == 2'b00);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= mode_t'(mode_i);
            bank_q <= last_bank(mode_i);
            seg0_q <= 3'd4;
            seg1_q <= 3'd5;
            seg2_q <= 3'd6;
            b3f_q  <= '0;
            hit_o  <= 1'b0;
        end else if (mode_i != mode_q) begin
            // New scheme: restart from its power-on banking, ignore any hotspot
            mode_q <= mode_t'(mode_i);
            bank_q <= last_bank(mode_i);
            seg0_q <= 3'd4;
            seg1_q <= 3'd5;
            seg2_q <= 3'd6;
            b3f_q  <= '0;
            hit_o  <= 1'b0;
        end else begin
            hit_o <= cpu_en_i && (hs_bank || hs_seg0 || hs_seg1 || hs_seg2 || hs_3f);
            if (cpu_en_i) begin
                if (hs_bank) bank_q <= bank_next;
                if (hs_seg0) seg0_q <= addr_i[2:0];
                if (hs_seg1) seg1_q <= addr_i[2:0];
                if (hs_seg2) seg2_q <= addr_i[2:0];
                if (hs_3f)   b3f_q  <= b3f_next;
            end
        end
    end

    always_comb begin
        logic [2:0] slice;
        case (addr_i[11:10])
            2'd0:    slice = seg0_q;
            2'd1:    slice = seg1_q;
            2'd2:    slice = seg2_q;
            default: slice = 3'd7;
        endcase
        case (mode_q)
            M_2K:               rom_addr_o = ROM_AW'(addr_i[10:0]);
            M_F8, M_F6, M_F4:   rom_addr_o = {bank_q, addr_i[11:0]};
            M_E0:               rom_addr_o = ROM_AW'({slice, addr_i[9:0]});
            M_3F:               rom_addr_o = addr_i[11] ? {{FW{1'b1}}, addr_i[10:0]}
                                                        : {b3f_q, addr_i[10:0]};
            default:            rom_addr_o = ROM_AW'(addr_i[11:0]);
        endcase
    end

    generate
        if (SC_SUPPORT) begin : g_sc
            logic sc_active;
            assign sc_active = sc_en_i && (mode_q == M_F8 || mode_q == M_F6 || mode_q == M_F4);
            // No R/W line on the cart: any access in the low window is a write
            assign sc_we_o   = sc_active && cpu_en_i && (addr_i[12:7] == 6'b100000);
            assign sc_rd_o   = sc_active && (addr_i[12:7] == 6'b100001);
            assign sc_addr_o = addr_i[6:0];
        end else begin : g_no_sc
            logic unused_sc;
            assign unused_sc = sc_en_i;
            assign sc_we_o   = 1'b0;
            assign sc_rd_o   = 1'b0;
            assign sc_addr_o = 7'd0;
        end
    endgenerate

endmodule
